// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file
// with write-to-read bypass and pending-write scoreboard.
module regfile_mp #(
  parameter int  XLEN   = 64,
  parameter int  NREGS  = 32,
  parameter int  NREAD  = 2,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       wd,
  input  logic [NREAD*AW-1:0]   rs,
  output logic [NREAD*XLEN-1:0] rdata,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [NREAD-1:0]      rs_busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic w_we;
  logic w_is;
  logic w_byp;

  assign w_byp = (BYPASS != 0);
  assign w_we  = write_enable & ~reset
               & (rd != '0);
  assign w_is  = issue_valid & ~reset
               & (issue_rd != '0);

  // Register storage: reset clears, otherwise writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[rd] <= wd;
    end
  end

  // Scoreboard: writeback clears, issue sets;
  // issue is applied last so a newer producer wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_we) r_busy[rd] <= 1'b0;
      if (w_is) r_busy[issue_rd] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_rs;
    logic          w_zero;
    logic          w_fwd;

    assign w_rs   = rs[g*AW +: AW];
    assign w_zero = (w_rs == '0);
    assign w_fwd  = w_byp & w_we
                  & (rd == w_rs);

    assign rdata[g*XLEN +: XLEN] =
      w_zero ? '0 :
      w_fwd  ? wd :
      r_regs[w_rs];

    assign rs_busy[g] = ~w_zero
                      & r_busy[w_rs]
                      & ~w_fwd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed bench for regfile_mp,
// one instance with bypass and one without.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [4:0]  rd;
  logic [63:0] wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  s0, s1;
  logic [9:0]  rs;
  logic [127:0] rdata_b, rdata_n;
  logic [1:0]  busy_b, busy_n;

  int passed = 0;
  int total  = 0;

  logic [63:0] m_reg [32];
  bit          m_busy [32];

  assign rs = {s1, s0};

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .write_enable(write_enable),
    .rd(rd), .wd(wd), .rs(rs),
    .rdata(rdata_b),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .rs_busy(busy_b)
  );

  regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset),
    .write_enable(write_enable),
    .rd(rd), .wd(wd), .rs(rs),
    .rdata(rdata_n),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .rs_busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] src(int p);
    return (p == 0) ? s0 : s1;
  endfunction

  function automatic bit we_eff();
    return write_enable && !reset && rd != 0;
  endfunction

  function automatic bit fwd(bit b, int p);
    return b && we_eff() && rd == src(p);
  endfunction

  function automatic logic [63:0] exp_data(bit b, int p);
    if (src(p) == 0) return 64'd0;
    if (fwd(b, p)) return wd;
    return m_reg[src(p)];
  endfunction

  function automatic bit exp_busy(bit b, int p);
    if (src(p) == 0) return 1'b0;
    return m_busy[src(p)] && !fwd(b, p);
  endfunction

  // Apply the architectural rules for this edge, then advance
  task automatic step();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 64'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we_eff()) begin
        m_reg[rd] = wd;
        m_busy[rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0)
        m_busy[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 0; rd = 0; wd = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); s0 = 0; s1 = 0;
    step();
    reset = 0;
    for (int i = 1; i < 32; i++) begin
      s0 = 5'(i); s1 = 5'(i); #1;
      total++;
      if (rdata_b !== 128'd0 ||
          rdata_n !== 128'd0 ||
          busy_b !== 2'b00 ||
          busy_n !== 2'b00)
        $display("FAIL reset idx=%0d rd=%h/%h busy=%b/%b want 0",
                 i, rdata_b, rdata_n, busy_b, busy_n);
      else passed++;
    end
  endtask

  task automatic test_write();
    write_enable = 1; rd = 1;
    wd = 64'hA5A5A5A5A5A5A5A5;
    s0 = 5; s1 = 0;
    step();
    idle(); s0 = 1; s1 = 0; #1;
    total++;
    if (rdata_b[63:0] !== 64'hA5A5A5A5A5A5A5A5 ||
        rdata_n[63:0] !== 64'hA5A5A5A5A5A5A5A5)
      $display("FAIL write rd0 got %h/%h want a5a5a5a5a5a5a5a5",
               rdata_b[63:0], rdata_n[63:0]);
    else passed++;
    total++;
    if (rdata_b[127:64] !== 64'd0 ||
        rdata_n[127:64] !== 64'd0)
      $display("FAIL write_x0 rd1 got %h/%h want 0",
               rdata_b[127:64], rdata_n[127:64]);
    else passed++;
  endtask

  task automatic test_bypass();
    write_enable = 1; rd = 2;
    wd = 64'h5A5A5A5A5A5A5A5A;
    s0 = 2; s1 = 1; #1;
    total++;
    if (rdata_b[63:0] !== 64'h5A5A5A5A5A5A5A5A)
      $display("FAIL bypass_on got %h want 5a5a5a5a5a5a5a5a",
               rdata_b[63:0]);
    else passed++;
    total++;
    if (rdata_n[63:0] !== 64'd0)
      $display("FAIL bypass_off got %h want 0",
               rdata_n[63:0]);
    else passed++;
    step();
    idle(); #1;
    total++;
    if (rdata_n[63:0] !== 64'h5A5A5A5A5A5A5A5A)
      $display("FAIL bypass_off_next got %h want 5a5a5a5a5a5a5a5a",
               rdata_n[63:0]);
    else passed++;
  endtask

  task automatic test_x0();
    for (int c = 0; c < 2; c++) begin
      write_enable = (c == 0); rd = 0;
      wd = '1;
      issue_valid = (c == 0); issue_rd = 0;
      s0 = 0; s1 = 0; #1;
      total++;
      if (rdata_b !== 128'd0 || rdata_n !== 128'd0 ||
          busy_b !== 2'b00 || busy_n !== 2'b00)
        $display("FAIL x0 cyc=%0d got %h/%h busy %b/%b want 0",
                 c, rdata_b, rdata_n, busy_b, busy_n);
      else passed++;
      step();
    end
    idle();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 5;
    s0 = 5; s1 = 0; #1;
    total++;
    if (busy_b[0] !== 1'b0)
      $display("FAIL sb_same_cycle got %b want 0", busy_b[0]);
    else passed++;
    step();
    idle(); #1;
    total++;
    if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1)
      $display("FAIL sb_set got %b/%b want 1/1",
               busy_b[0], busy_n[0]);
    else passed++;
    write_enable = 1; rd = 5; wd = 64'h1234; #1;
    total++;
    if (busy_b[0] !== 1'b0 ||
        rdata_b[63:0] !== 64'h1234)
      $display("FAIL sb_fwd got busy=%b data=%h want 0/1234",
               busy_b[0], rdata_b[63:0]);
    else passed++;
    total++;
    if (busy_n[0] !== 1'b1 || rdata_n[63:0] !== 64'd0)
      $display("FAIL sb_nofwd got busy=%b data=%h want 1/0",
               busy_n[0], rdata_n[63:0]);
    else passed++;
    step();
    idle(); #1;
    total++;
    if (busy_n[0] !== 1'b0 ||
        rdata_n[63:0] !== 64'h1234)
      $display("FAIL sb_clear got busy=%b data=%h want 0/1234",
               busy_n[0], rdata_n[63:0]);
    else passed++;
  endtask

  task automatic test_set_clear();
    issue_valid = 1; issue_rd = 7; s0 = 7;
    step();
    write_enable = 1; rd = 7; wd = 64'h77; #1;
    total++;
    if (busy_b[0] !== 1'b0 || rdata_b[63:0] !== 64'h77)
      $display("FAIL setclr_fwd got busy=%b data=%h want 0/77",
               busy_b[0], rdata_b[63:0]);
    else passed++;
    step();
    idle(); #1;
    total++;
    if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1)
      $display("FAIL setclr_busy got %b/%b want 1/1",
               busy_b[0], busy_n[0]);
    else passed++;
    total++;
    if (rdata_b[63:0] !== 64'h77 || rdata_n[63:0] !== 64'h77)
      $display("FAIL setclr_data got %h/%h want 77",
               rdata_b[63:0], rdata_n[63:0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    write_enable = 1; rd = 3; wd = 64'hDEAD;
    step();
    idle(); issue_valid = 1; issue_rd = 3;
    step();
    idle();
    reset = 1; write_enable = 1; rd = 3; wd = 64'hBEEF;
    s0 = 3; s1 = 3; #1;
    total++;
    if (rdata_b !== {2{64'hDEAD}} ||
        rdata_n !== {2{64'hDEAD}})
      $display("FAIL rstmid_hold got %h/%h want dead",
               rdata_b, rdata_n);
    else passed++;
    total++;
    if (busy_b !== 2'b11 || busy_n !== 2'b11)
      $display("FAIL rstmid_busy got %b/%b want 11/11",
               busy_b, busy_n);
    else passed++;
    step();
    reset = 0; idle(); #1;
    total++;
    if (rdata_b !== 128'd0 || rdata_n !== 128'd0 ||
        busy_b !== 2'b00 || busy_n !== 2'b00)
      $display("FAIL rstmid_clear got %h/%h busy %b/%b want 0",
               rdata_b, rdata_n, busy_b, busy_n);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      write_enable = $urandom_range(0, 1);
      rd = 5'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      issue_valid = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 7));
      s0 = 5'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 3) == 0) ? s0
           : 5'($urandom_range(0, 31));
      #1;
      for (int p = 0; p < 2; p++) begin
        total++;
        if (rdata_b[p*64 +: 64] !== exp_data(1, p) ||
            busy_b[p] !== exp_busy(1, p))
          $display("FAIL rand_byp c=%0d p=%0d got %h/%b want %h/%b",
                   c, p, rdata_b[p*64 +: 64], busy_b[p],
                   exp_data(1, p), exp_busy(1, p));
        else passed++;
        total++;
        if (rdata_n[p*64 +: 64] !== exp_data(0, p) ||
            busy_n[p] !== exp_busy(0, p))
          $display("FAIL rand_nob c=%0d p=%0d got %h/%b want %h/%b",
                   c, p, rdata_n[p*64 +: 64], busy_n[p],
                   exp_data(0, p), exp_busy(0, p));
        else passed++;
      end
      step();
    end
    reset = 0; idle();
  endtask

  initial begin
    reset = 1; idle(); s0 = 0; s1 = 0;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
